// File: rtl/dp_jtag_master.sv
// JTAG scan sequencer: per command an optional IR scan, then an optional DR scan, back to Run-Test/Idle.
// Define DP_JTAG_MASTER_FREE_TCK_EN to keep tck running in IDLE (TAP held in Run-Test/Idle).
module dp_jtag_master #(
    parameter int DIV  = 2,
    parameter int IR_W = 5,
    parameter int DR_W = 32
) (
    input  logic            iclk,
    input  logic            trst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_skip_ir,
    input  logic [IR_W-1:0] cmd_ir,
    input  logic [5:0]      cmd_len,
    input  logic [DR_W-1:0] cmd_dr,
    output logic            rsp_valid,
    output logic [IR_W-1:0] rsp_ir,
    output logic [DR_W-1:0] rsp_dr,
    output logic            busy,
    output logic            tck,
    output logic            tms,
    output logic            tdi,
    input  logic            tdo
);
    localparam int LW   = $clog2(DR_W + 1);
    localparam int IRCW = $clog2(IR_W + 1);
    localparam int CW0  = (LW > 3) ? LW : 3;
    localparam int CW   = (IRCW > CW0) ? IRCW : CW0;
    localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [3:0] {
        S_RST, S_IDLE, S_IR_HDR, S_IR_SHIFT, S_IR_TAIL,
        S_DR_HDR, S_DR_SHIFT, S_DR_TAIL, S_DONE
    } state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic [DIVW-1:0] r_div;
    logic            r_tck;
    logic [IR_W-1:0] r_ir, r_ir_sh, r_rsp_ir;
    logic [DR_W-1:0] r_dr, r_dr_sh, r_rsp_dr;
    logic [LW-1:0]   r_len, w_len_clamp;
    logic [CW-1:0]   w_len_m1;
    logic            w_run, w_phase_end, w_rise, w_fall, w_last;
    logic            w_tms, w_tdi, w_accept, w_ready;

    assign w_len_clamp = (int'(cmd_len) > DR_W) ? LW'(DR_W) : LW'(cmd_len);
    assign w_len_m1    = CW'(r_len) - CW'(1);
    assign w_phase_end = (r_div == DIVW'(DIV - 1));
    assign w_rise      = w_run && !r_tck && w_phase_end;
    assign w_fall      = w_run &&  r_tck && w_phase_end;

`ifdef DP_JTAG_MASTER_FREE_TCK_EN
    // Accept only at a tck falling point so the header starts on a fresh low phase.
    assign w_run   = (r_state != S_DONE);
    assign w_ready = (r_state == S_IDLE) && w_fall;
`else
    assign w_run   = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_ready = (r_state == S_IDLE);
`endif

    assign w_accept  = cmd_valid && w_ready;
    assign cmd_ready = w_ready;
    assign busy      = (r_state != S_IDLE);
    assign rsp_valid = (r_state == S_DONE);
    assign rsp_ir    = r_rsp_ir;
    assign rsp_dr    = r_rsp_dr;
    assign tck       = r_tck;
    assign tms       = w_tms;
    assign tdi       = w_tdi;

    // Each state spans a number of tck periods; it advances at the period's closing fall.
    always_comb begin
        w_next = r_state;
        w_tms  = 1'b0;
        w_tdi  = 1'b0;
        w_last = 1'b0;
        unique case (r_state)
            S_RST: begin
                w_tms  = (r_cnt < CW'(5));
                w_last = (r_cnt == CW'(5));
                if (w_fall && w_last) w_next = S_IDLE;
            end
            S_IDLE: begin
                w_last = 1'b1;
                if (w_accept) begin
                    if (!cmd_skip_ir)         w_next = S_IR_HDR;
                    else if (cmd_len != 6'd0) w_next = S_DR_HDR;
                    else                      w_next = S_DONE;
                end
            end
            S_IR_HDR: begin
                w_tms  = (r_cnt < CW'(2));
                w_last = (r_cnt == CW'(3));
                if (w_fall && w_last) w_next = S_IR_SHIFT;
            end
            S_IR_SHIFT: begin
                w_tdi  = r_ir[0];
                w_last = (r_cnt == CW'(IR_W - 1));
                w_tms  = w_last;
                if (w_fall && w_last) w_next = S_IR_TAIL;
            end
            S_IR_TAIL: begin
                w_tms  = (r_cnt == CW'(0));
                w_last = (r_cnt == CW'(1));
                if (w_fall && w_last) w_next = (r_len != '0) ? S_DR_HDR : S_DONE;
            end
            S_DR_HDR: begin
                w_tms  = (r_cnt == CW'(0));
                w_last = (r_cnt == CW'(2));
                if (w_fall && w_last) w_next = S_DR_SHIFT;
            end
            S_DR_SHIFT: begin
                w_tdi  = r_dr[0];
                w_last = (r_cnt == w_len_m1);
                w_tms  = w_last;
                if (w_fall && w_last) w_next = S_DR_TAIL;
            end
            S_DR_TAIL: begin
                w_tms  = (r_cnt == CW'(0));
                w_last = (r_cnt == CW'(1));
                if (w_fall && w_last) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_RST;
        endcase
    end

    always_ff @(posedge iclk or negedge trst) begin
        if (!trst) begin
            r_state  <= S_RST;
            r_cnt    <= '0;
            r_div    <= '0;
            r_tck    <= 1'b0;
            r_ir     <= '0;
            r_dr     <= '0;
            r_len    <= '0;
            r_ir_sh  <= '0;
            r_dr_sh  <= '0;
            r_rsp_ir <= '0;
            r_rsp_dr <= '0;
        end else begin
            r_state <= w_next;

            if (w_run) begin
                if (w_phase_end) begin
                    r_div <= '0;
                    r_tck <= ~r_tck;
                end else begin
                    r_div <= r_div + DIVW'(1);
                end
            end else begin
                r_div <= '0;
                r_tck <= 1'b0;
            end

            if (w_fall) r_cnt <= w_last ? '0 : r_cnt + CW'(1);

            // Command words double as tdi shift registers, LSB first.
            if (w_accept) begin
                r_ir  <= cmd_ir;
                r_dr  <= cmd_dr;
                r_len <= w_len_clamp;
            end else begin
                if (w_fall && r_state == S_IR_SHIFT) r_ir <= r_ir >> 1;
                if (w_fall && r_state == S_DR_SHIFT) r_dr <= r_dr >> 1;
            end

            if (r_state == S_DONE)
                r_ir_sh <= '0;
            else if (w_rise && r_state == S_IR_SHIFT)
                r_ir_sh <= {tdo, r_ir_sh[IR_W-1:1]};

            // Capture fills from the MSB; short scans are right-aligned once complete.
            if (r_state == S_DONE)
                r_dr_sh <= '0;
            else if (w_rise && r_state == S_DR_SHIFT)
                r_dr_sh <= {tdo, r_dr_sh[DR_W-1:1]};
            else if (w_fall && w_last && r_state == S_DR_SHIFT)
                r_dr_sh <= r_dr_sh >> (DR_W - int'(r_len));

            if (w_next == S_DONE && r_state != S_DONE) begin
                r_rsp_ir <= r_ir_sh;
                r_rsp_dr <= r_dr_sh;
            end
        end
    end
endmodule

// File: tb/tb_dp_jtag_master.sv
// Directed bench for dp_jtag_master with a small TAP model (IDCODE/BYPASS) and a tdo=tdi loopback.
module tb_dp_jtag_master;
    localparam int DIV = 2, IR_W = 5, DR_W = 32;
    localparam logic [4:0]  IDC    = 5'h0E;
    localparam logic [4:0]  BYP    = 5'h1F;
    localparam logic [31:0] IDCODE = 32'h10000802;

    logic iclk = 1'b0, trst = 1'b0, cmd_valid = 1'b0, cmd_skip_ir = 1'b0;
    logic [4:0]  cmd_ir = '0;
    logic [5:0]  cmd_len = '0;
    logic [31:0] cmd_dr = '0;
    logic cmd_ready, rsp_valid, busy, tck, tms, tdi;
    logic [4:0]  rsp_ir;
    logic [31:0] rsp_dr;
    logic loop = 1'b0, m_tdo = 1'b0;
    wire  tdo = loop ? tdi : m_tdo;

    int checks = 0, failures = 0, tck_edges = 0, rv_cnt = 0;
    logic tms_log[$];

    always #5 iclk = ~iclk;

    dp_jtag_master #(.DIV(DIV), .IR_W(IR_W), .DR_W(DR_W)) dut (
        .iclk(iclk), .trst(trst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_skip_ir(cmd_skip_ir), .cmd_ir(cmd_ir), .cmd_len(cmd_len), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_ir(rsp_ir), .rsp_dr(rsp_dr), .busy(busy),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    // ---- TAP model ----
    typedef enum {TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
                  SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_t;
    tap_t m_st = TLR;
    logic [4:0]  m_ir = IDC, m_irsh = '0;
    logic [31:0] m_drsh = '0;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR:  return m ? TLR  : RTI;
            RTI:  return m ? SDR  : RTI;
            SDR:  return m ? SIR  : CDR;
            CDR:  return m ? E1DR : SHDR;
            SHDR: return m ? E1DR : SHDR;
            E1DR: return m ? UDR  : PDR;
            PDR:  return m ? E2DR : PDR;
            E2DR: return m ? UDR  : SHDR;
            UDR:  return m ? SDR  : RTI;
            SIR:  return m ? TLR  : CIR;
            CIR:  return m ? E1IR : SHIR;
            SHIR: return m ? E1IR : SHIR;
            E1IR: return m ? UIR  : PIR;
            PIR:  return m ? E2IR : PIR;
            E2IR: return m ? UIR  : SHIR;
            default: return m ? SDR : RTI;
        endcase
    endfunction

    always @(posedge tck) begin
        case (m_st)
            TLR:  m_ir <= IDC;
            CIR:  m_irsh <= 5'b00001;
            SHIR: m_irsh <= {tdi, m_irsh[4:1]};
            UIR:  m_ir <= m_irsh;
            CDR:  m_drsh <= (m_ir == IDC) ? IDCODE : 32'h0;
            SHDR: m_drsh <= (m_ir == IDC) ? {tdi, m_drsh[31:1]} : {31'h0, tdi};
            default: ;
        endcase
        m_st <= tap_next(m_st, tms);
        tck_edges <= tck_edges + 1;
        tms_log.push_back(tms);
    end

    always @(negedge tck)
        m_tdo <= (m_st == SHDR) ? m_drsh[0] : (m_st == SHIR) ? m_irsh[0] : 1'b0;

    always @(negedge iclk) if (rsp_valid === 1'b1) rv_cnt <= rv_cnt + 1;

    // ---- checking helpers ----
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 3000) begin
            @(negedge iclk);
            n++;
        end
        if (cmd_ready !== 1'b1) chk({nm, "_ready_timeout"}, 64'(cmd_ready), 64'd1);
    endtask

    task automatic chk_reset_seq(input string nm, input int e0);
        chk({nm, "_rst_edges"}, 64'(tck_edges - e0), 64'd6);
        for (int k = 0; k < 6 && k < tms_log.size(); k++)
            chk($sformatf("%s_rst_tms%0d", nm, k), 64'(tms_log[k]), 64'(k < 5));
        chk({nm, "_busy_idle"}, 64'(busy), 64'd0);
    endtask

    typedef struct {
        logic        skip;
        logic [4:0]  ir;
        logic [5:0]  len;
        logic [31:0] dr;
        logic        lp;
        logic        ctms;
        logic [4:0]  eir;
        logic [31:0] edr;
    } vec_t;

    function automatic int exp_edges(input vec_t v);
        int n = 0;
        int l = (v.len > 6'd32) ? 32 : int'(v.len);
        if (!v.skip) n += 4 + IR_W + 2;
        if (l != 0)  n += 3 + l + 2;
        return n;
    endfunction

    task automatic run_cmd(input int id, input vec_t v);
        int e0, cyc, rv0;
        string nm = $sformatf("v%0d", id);
        wait_ready(nm);
        loop = v.lp;
        cmd_skip_ir = v.skip; cmd_ir = v.ir; cmd_len = v.len; cmd_dr = v.dr;
        cmd_valid = 1'b1;
        e0 = tck_edges;
        rv0 = rv_cnt;
        tms_log.delete();
        @(posedge iclk);
        @(negedge iclk);
        cmd_valid = 1'b0;
        cyc = 1;
        if (!(v.skip && v.len == 6'd0))
            chk({nm, "_ready_low"}, 64'(cmd_ready), 64'd0);
        while (rsp_valid !== 1'b1 && cyc < 3000) begin
            @(negedge iclk);
            cyc++;
        end
        chk({nm, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
        chk({nm, "_rsp_ir"}, 64'(rsp_ir), 64'(v.eir));
        chk({nm, "_rsp_dr"}, 64'(rsp_dr), 64'(v.edr));
        chk({nm, "_tck_edges"}, 64'(tck_edges - e0), 64'(exp_edges(v)));
        if (v.skip && v.len == 6'd0) chk({nm, "_latency"}, 64'(cyc), 64'd1);
        if (v.ctms) begin
            chk({nm, "_tms_len"}, 64'(tms_log.size()), 64'd37);
            for (int k = 0; k < 37 && k < tms_log.size(); k++)
                chk($sformatf("%s_tms%0d", nm, k), 64'(tms_log[k]),
                    64'(k == 0 || k == 34 || k == 35));
        end
        @(negedge iclk);
        chk({nm, "_one_pulse"}, 64'(rv_cnt - rv0), 64'd1);
        chk({nm, "_ready_back"}, 64'(cmd_ready), 64'd1);
        chk({nm, "_hold_dr"}, 64'(rsp_dr), 64'(v.edr));
        chk({nm, "_tck_parked"}, 64'(tck), 64'd0);
    endtask

    vec_t vecs[8];

    initial begin
        int e0, rv0, n;
        vecs[0] = '{1'b0, IDC,   6'd32, 32'h0,        1'b0, 1'b0, 5'h01, IDCODE};
        vecs[1] = '{1'b0, BYP,   6'd8,  32'h000000A5, 1'b0, 1'b0, 5'h01, 32'h0000004A};
        vecs[2] = '{1'b1, 5'h00, 6'd32, 32'hDEADBEEF, 1'b1, 1'b1, 5'h00, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 5'h00, 6'd40, 32'h12345678, 1'b1, 1'b0, 5'h00, 32'h12345678};
        vecs[4] = '{1'b1, 5'h00, 6'd0,  32'hFFFFFFFF, 1'b1, 1'b0, 5'h00, 32'h0};
        vecs[5] = '{1'b0, 5'h15, 6'd4,  32'hFFFFFFFB, 1'b1, 1'b0, 5'h15, 32'h0000000B};
        vecs[6] = '{1'b0, 5'h0A, 6'd0,  32'h0,        1'b1, 1'b0, 5'h0A, 32'h0};
        vecs[7] = '{1'b0, IDC,   6'd16, 32'h0,        1'b0, 1'b0, 5'h01, 32'h00000802};

        // Reset state
        repeat (3) @(negedge iclk);
        chk("rst_tck", 64'(tck), 64'd0);
        chk("rst_tms", 64'(tms), 64'd1);
        chk("rst_tdi", 64'(tdi), 64'd0);
        chk("rst_ready", 64'(cmd_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_rsp", {31'h0, rsp_valid, rsp_ir, rsp_dr[27:0]}, 64'd0);
        chk("rst_rsp_dr", 64'(rsp_dr), 64'd0);
        e0 = tck_edges;
        tms_log.delete();
        trst = 1'b1;
        wait_ready("init");
        chk_reset_seq("init", e0);

        for (int i = 0; i < 8; i++) run_cmd(i, vecs[i]);

        // cmd_valid while busy is ignored: a second request mid-scan produces no extra response
        wait_ready("busy");
        loop = 1'b1;
        cmd_skip_ir = 1'b1; cmd_len = 6'd8; cmd_dr = 32'h0000003C; cmd_valid = 1'b1;
        rv0 = rv_cnt;
        @(posedge iclk);
        @(negedge iclk);
        cmd_dr = 32'h000000FF;
        repeat (10) @(negedge iclk);
        cmd_valid = 1'b0;
        wait_ready("busy2");
        repeat (2) @(negedge iclk);
        chk("busy_ignored_pulses", 64'(rv_cnt - rv0), 64'd1);
        chk("busy_ignored_dr", 64'(rsp_dr), 64'h3C);

        // Abort during DR_SHIFT bit 10
        wait_ready("abort");
        loop = 1'b1;
        cmd_skip_ir = 1'b1; cmd_len = 6'd32; cmd_dr = 32'hCAFEF00D; cmd_valid = 1'b1;
        @(posedge iclk);
        @(negedge iclk);
        cmd_valid = 1'b0;
        e0 = tck_edges;
        rv0 = rv_cnt;
        n = 0;
        while ((tck_edges - e0) < 14 && n < 1000) begin
            @(negedge iclk);
            n++;
        end
        chk("abort_reach_bit10", 64'(tck_edges - e0), 64'd14);
        trst = 1'b0;
        #1;
        chk("abort_tck", 64'(tck), 64'd0);
        chk("abort_tms", 64'(tms), 64'd1);
        chk("abort_busy", 64'(busy), 64'd1);
        chk("abort_ready", 64'(cmd_ready), 64'd0);
        repeat (3) @(negedge iclk);
        chk("abort_rsp_dr", 64'(rsp_dr), 64'd0);
        e0 = tck_edges;
        tms_log.delete();
        trst = 1'b1;
        wait_ready("abort_rel");
        chk_reset_seq("abort", e0);
        chk("abort_no_rsp", 64'(rv_cnt - rv0), 64'd0);

        // TAP still usable after the abort
        run_cmd(8, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dp_jtag_master.md
Name: dp_jtag_master

Overview:
- Scan sequencer that drives the debug access port's JTAG pins (tck/tms/tdi) from a system-side command interface.
- Each command performs an optional IR scan, then an optional DR scan, and returns to Run-Test/Idle.
- Returns the captured IR and DR bits from tdo.
- Sits between the on-chip debug host logic and the dp_dap pins; it is the only master of the TAP.

Parameters:
DIV, 2, tck half-period in iclk cycles (>=1); one tck period = 2*DIV iclk cycles
IR_W, 5, instruction register length
DR_W, 32, maximum DR scan length

Ports:
iclk  in  1  system clock
trst  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_skip_ir  in  1  1 = no IR scan
cmd_ir  in  IR_W  instruction shifted LSB first
cmd_len  in  6  DR bits to shift, 0 = no DR scan, values >DR_W clamp to DR_W
cmd_dr  in  DR_W  DR data shifted LSB first
rsp_valid  out  1  one-cycle pulse at end of command
rsp_ir  out  IR_W  captured IR bits
rsp_dr  out  DR_W  captured DR bits in [len-1:0], upper bits zero
busy  out  1  sequence in progress
tck  out  1  JTAG clock
tms  out  1  JTAG mode select
tdi  out  1  JTAG data to DAP
tdo  in  1  JTAG data from DAP

Behaviour:
- Reset values while trst low: tck=0, tms=1, tdi=0, cmd_ready=0, busy=1, rsp_valid=0, rsp_ir=0, rsp_dr=0, all state to RST_SEQ.
- Reset mid-operation aborts immediately. No rsp_valid is issued. The sequence restarts from RST_SEQ on release.
- tck generation: a divider counts DIV iclk cycles per phase. tms/tdi update at the iclk edge where tck falls (or at phase start). tdo is sampled at the iclk edge where tck rises.
- FSM states and tms values, one entry per tck period:
  - RST_SEQ: tms=1 for 5 tck, then tms=0 for 1 tck, ending in Run-Test/Idle. Then IDLE.
  - IDLE: tck parked low, tms=0, cmd_ready=1, busy=0. Accept on cmd_valid&&cmd_ready and latch all cmd fields.
    - skip_ir=0: go to IR_HDR.
    - skip_ir=1 and len!=0: go to DR_HDR.
    - skip_ir=1 and len=0: go to DONE.
  - IR_HDR: tms 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
  - IR_SHIFT: IR_W tck. tdi=cmd_ir[i]. tms=0 except the last bit, where tms=1 (Exit1-IR). Sampled tdo enters at the MSB of a shift register that shifts right.
  - IR_TAIL: tms 1 (Update-IR), 0 (Run-Test/Idle). Then DR_HDR if len!=0, else DONE.
  - DR_HDR: tms 1,0,0 (Select-DR, Capture-DR, Shift-DR).
  - DR_SHIFT: len tck. tdi=cmd_dr[i]. The last bit has tms=1. Captured bits are right-aligned by shifting DR_W-len positions at completion.
  - DR_TAIL: tms 1 (Update-DR), 0 (Run-Test/Idle). Then DONE.
  - DONE: one iclk cycle. rsp_valid=1 and rsp_ir/rsp_dr updated. Next cycle is IDLE.
- Skipped scans leave their rsp field at 0.
- rsp fields hold until the next DONE.
- cmd_ready falls in the cycle after acceptance and rises the cycle after rsp_valid.
- cmd_valid while busy is ignored.
- Bit counter width is clog2(DR_W+1). Counter wraps are not possible because of clamping.
- tck is always 0 on IDLE entry. The last tck period completes fully before DONE.

Optional Feature:
- Macro: DP_JTAG_MASTER_FREE_TCK_EN.
- Defined: tck toggles continuously in IDLE with tms=0, keeping the TAP in Run-Test/Idle and the DAP internal clock running. Command acceptance waits for tck low phase start, so header alignment is unchanged.
- Undefined: tck is parked low in IDLE and no edges are produced between commands.

Test Plan:
- Reset: trst low 3 cycles then high, DIV=2 -> exactly 6 tck rising edges (tms=1 x5, then 0), then cmd_ready=1, busy=0.
- IDCODE read against dp_dap: IDCODE instruction, len=32 -> rsp_ir=5'h01, rsp_dr=32'h10000802, one rsp_valid pulse.
- Bypass against dp_dap: BYPASS instruction, len=8, cmd_dr=8'hA5 -> rsp_dr=32'h0000004A (one-bit delay, first bit 0).
- Loopback tdo=tdi, skip_ir=1, len=32, cmd_dr=32'hDEADBEEF -> rsp_dr=32'hDEADBEEF, rsp_ir=0. Bench checks tms sequence 1,0,0,0x31,1,1,0.
- Abort: trst low during DR_SHIFT bit 10 -> tck=0 and tms=1 the same cycle, no rsp_valid, full reset sequence replayed after release.
- Edge lengths:
  - skip_ir=1, len=0 -> rsp_valid 1 cycle after acceptance with zero tck edges.
  - len=40 in loopback -> 32 shift bits, rsp_dr=cmd_dr.
